// File: rtl/instr_fetch.sv
// Instruction fetch unit: owns the PC, drives a combinational instruction memory and
// registers the returned word into a valid/ready output stage. Optional halt: IFETCH_HALT_EN.
module instr_fetch #(
  parameter logic [4:0]  RESET_PC  = 5'd0,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [4:0]  imem_addr,
  input  logic [31:0] imem_dout,
  input  logic        redirect_valid,
  input  logic [4:0]  redirect_addr,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [4:0]  out_pc,
  input  logic        out_ready,
  output logic        halted
);

  // state | meaning
  // IDLE  | after reset, waiting for start
  // FETCH | loading one word per cycle when the output stage is free
  // HALT  | halt word seen; no loads until a redirect
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HALT  = 2'd2
  } state_t;

`ifdef IFETCH_HALT_EN
  localparam logic HALT_EN = 1'b1;
`else
  localparam logic HALT_EN = 1'b0;
`endif

  state_t      r_state;
  state_t      w_state_nxt;
  logic [4:0]  r_pc;
  logic [4:0]  w_pc_nxt;
  logic        r_out_valid;
  logic        w_out_valid_nxt;
  logic [31:0] r_out_instr;
  logic [31:0] w_out_instr_nxt;
  logic [4:0]  r_out_pc;
  logic [4:0]  w_out_pc_nxt;
  logic        r_halted;
  logic        w_halted_nxt;
  logic        w_load;
  logic        w_halt_hit;

  assign w_load     = (r_state == S_FETCH) && (!r_out_valid || out_ready) && !redirect_valid;
  assign w_halt_hit = HALT_EN && (imem_dout == HALT_WORD);

  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_out_valid_nxt = r_out_valid;
    w_out_instr_nxt = r_out_instr;
    w_out_pc_nxt    = r_out_pc;
    w_halted_nxt    = r_halted;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = S_FETCH;
      end
      S_FETCH, S_HALT: begin
        if (redirect_valid) begin
          // same-cycle accept of the flushed word is void on the decode side
          w_pc_nxt        = redirect_addr;
          w_out_valid_nxt = 1'b0;
          w_state_nxt     = S_FETCH;
          w_halted_nxt    = 1'b0;
        end else if (w_load) begin
          w_out_instr_nxt = imem_dout;
          w_out_pc_nxt    = r_pc;
          w_out_valid_nxt = 1'b1;
          if (w_halt_hit) begin
            w_state_nxt  = S_HALT;
            w_halted_nxt = 1'b1;
          end else begin
            w_pc_nxt = r_pc + 5'd1;
          end
        end else if (r_out_valid && out_ready) begin
          w_out_valid_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc        <= RESET_PC;
      r_out_valid <= 1'b0;
      r_out_instr <= 32'd0;
      r_out_pc    <= 5'd0;
      r_halted    <= 1'b0;
    end else begin
      r_pc        <= w_pc_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_instr <= w_out_instr_nxt;
      r_out_pc    <= w_out_pc_nxt;
      r_halted    <= w_halted_nxt;
    end
  end

  assign imem_addr = r_pc;
  assign out_valid = r_out_valid;
  assign out_instr = r_out_instr;
  assign out_pc    = r_out_pc;
  assign halted    = r_halted;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: scoreboard of expected {pc, instr} pairs popped
// on every accepted handshake. The halt scenario follows IFETCH_HALT_EN.
module tb_instr_fetch;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [4:0]  imem_addr;
  logic [31:0] imem_dout;
  logic        redirect_valid;
  logic [4:0]  redirect_addr;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [4:0]  out_pc;
  logic        out_ready;
  logic        halted;

  logic [31:0] mem [32];
  logic [36:0] sb [$];
  logic [36:0] exp_e;
  int total;
  int bad;

  instr_fetch dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .imem_addr(imem_addr), .imem_dout(imem_dout),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
    .out_ready(out_ready), .halted(halted)
  );

  assign imem_dout = mem[imem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; redirect_valid = 1'b0; redirect_addr = 5'd0; out_ready = 1'b0;
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic do_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic push_range(input int lo, input int n);
    for (int i = 0; i < n; i++) begin
      logic [4:0] p;
      p = 5'(lo + i);
      sb.push_back({p, 32'h1000_0000 + 32'(p)});
    end
  endtask

  task automatic check_drained(input string name);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL %s timeout: %0d expected words left, want 0", name, sb.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; redirect_valid = 1'b0; redirect_addr = 5'd0; out_ready = 1'b0;
    #1;
    total++;
    if ({out_valid, out_instr, out_pc, imem_addr, halted} !== {1'b0, 32'd0, 5'd0, 5'd0, 1'b0}) begin
      bad++;
      $display("FAIL reset_vals got v=%b i=%h p=%0d a=%0d h=%b want 0/0/0/0/0",
               out_valid, out_instr, out_pc, imem_addr, halted);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    // redirect and ready must be ignored in IDLE
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      redirect_valid = 1'b1; redirect_addr = 5'd9; out_ready = 1'b1;
      #1;
      total++;
      if ({out_valid, imem_addr} !== {1'b0, 5'd0}) begin
        bad++;
        $display("FAIL idle_hold got v=%b a=%0d want v=0 a=0", out_valid, imem_addr);
      end
    end
    @(negedge clk); redirect_valid = 1'b0;
  endtask

  task automatic test_stream();
    int bubbles;
    bubbles = 0;
    do_reset();
    push_range(0, 34);
    out_ready = 1'b1;
    do_start();
    for (int c = 0; c < 60 && sb.size() > 0; c++) begin
      @(negedge clk); #2;
      if (!out_valid) bubbles++;
      if (out_valid && out_ready && !redirect_valid) begin
        exp_e = sb.pop_front(); total++;
        if ({out_pc, out_instr} !== exp_e) begin
          bad++;
          $display("FAIL stream got pc=%0d instr=%h want pc=%0d instr=%h", out_pc, out_instr, exp_e[36:32], exp_e[31:0]);
        end
      end
    end
    check_drained("stream");
    total++;
    if (bubbles != 0) begin
      bad++;
      $display("FAIL throughput got %0d bubbles want 0", bubbles);
    end
  endtask

  task automatic test_backpressure();
    int hold;
    hold = 0;
    do_reset();
    push_range(0, 8);
    out_ready = 1'b1;
    do_start();
    for (int c = 0; c < 40 && sb.size() > 0; c++) begin
      @(negedge clk); #1;
      out_ready = 1'b1;
      if (out_valid && out_pc == 5'd3 && hold < 4) begin
        out_ready = 1'b0;
        hold++;
        total++;
        if ({out_pc, out_instr, imem_addr} !== {5'd3, 32'h1000_0003, 5'd4}) begin
          bad++;
          $display("FAIL bp_hold got pc=%0d instr=%h a=%0d want 3/10000003/4", out_pc, out_instr, imem_addr);
        end
      end
      #1;
      if (out_valid && out_ready && !redirect_valid) begin
        exp_e = sb.pop_front(); total++;
        if ({out_pc, out_instr} !== exp_e) begin
          bad++;
          $display("FAIL bp_stream got pc=%0d instr=%h want pc=%0d instr=%h", out_pc, out_instr, exp_e[36:32], exp_e[31:0]);
        end
      end
    end
    check_drained("bp");
    total++;
    if (hold != 4) begin
      bad++;
      $display("FAIL bp_cycles got %0d held cycles want 4", hold);
    end
  endtask

  task automatic test_redirect(input logic with_bp);
    int hold;
    logic done;
    logic bubble_chk;
    logic [4:0] stop_pc;
    logic [4:0] tgt;
    hold = 0; done = 1'b0; bubble_chk = 1'b0;
    stop_pc = with_bp ? 5'd2 : 5'd7;
    tgt     = with_bp ? 5'd10 : 5'd20;
    do_reset();
    push_range(0, int'(stop_pc));
    push_range(int'(tgt), 4);
    out_ready = 1'b1;
    do_start();
    for (int c = 0; c < 40 && sb.size() > 0; c++) begin
      @(negedge clk); #1;
      out_ready = 1'b1; redirect_valid = 1'b0;
      if (bubble_chk) begin
        bubble_chk = 1'b0;
        total++;
        if ({out_valid, imem_addr} !== {1'b0, tgt}) begin
          bad++;
          $display("FAIL redir_bubble got v=%b a=%0d want v=0 a=%0d", out_valid, imem_addr, tgt);
        end
      end
      if (!done && out_valid && out_pc == stop_pc) begin
        if (with_bp) begin
          out_ready = 1'b0;
          hold++;
        end
        if (!with_bp || hold == 2) begin
          redirect_valid = 1'b1; redirect_addr = tgt;
          done = 1'b1; bubble_chk = 1'b1;
        end
      end
      #1;
      if (out_valid && out_ready && !redirect_valid) begin
        exp_e = sb.pop_front(); total++;
        if ({out_pc, out_instr} !== exp_e) begin
          bad++;
          $display("FAIL redir_stream got pc=%0d instr=%h want pc=%0d instr=%h", out_pc, out_instr, exp_e[36:32], exp_e[31:0]);
        end
      end
    end
    redirect_valid = 1'b0;
    check_drained(with_bp ? "redir_bp" : "redir");
  endtask

  task automatic test_halt();
    do_reset();
    mem[6] = 32'hFFFF_FFFF;
    push_range(0, 6);
    sb.push_back({5'd6, 32'hFFFF_FFFF});
`ifndef IFETCH_HALT_EN
    push_range(7, 3);
`endif
    out_ready = 1'b1;
    do_start();
    for (int c = 0; c < 30 && sb.size() > 0; c++) begin
      @(negedge clk); #2;
      if (out_valid && out_ready && !redirect_valid) begin
        exp_e = sb.pop_front(); total++;
        if ({out_pc, out_instr} !== exp_e) begin
          bad++;
          $display("FAIL halt_stream got pc=%0d instr=%h want pc=%0d instr=%h", out_pc, out_instr, exp_e[36:32], exp_e[31:0]);
        end
      end
    end
    check_drained("halt_stream");
`ifdef IFETCH_HALT_EN
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #2;
      total++;
      if ({halted, out_valid, imem_addr} !== {1'b1, 1'b0, 5'd6}) begin
        bad++;
        $display("FAIL halt_hold got h=%b v=%b a=%0d want h=1 v=0 a=6", halted, out_valid, imem_addr);
      end
    end
    @(negedge clk); redirect_valid = 1'b1; redirect_addr = 5'd0;
    @(negedge clk); redirect_valid = 1'b0; #1;
    total++;
    if ({halted, out_valid, imem_addr} !== {1'b0, 1'b0, 5'd0}) begin
      bad++;
      $display("FAIL halt_exit got h=%b v=%b a=%0d want h=0 v=0 a=0", halted, out_valid, imem_addr);
    end
    push_range(0, 3);
    for (int c = 0; c < 20 && sb.size() > 0; c++) begin
      @(negedge clk); #2;
      if (out_valid && out_ready && !redirect_valid) begin
        exp_e = sb.pop_front(); total++;
        if ({out_pc, out_instr} !== exp_e) begin
          bad++;
          $display("FAIL halt_resume got pc=%0d instr=%h want pc=%0d instr=%h", out_pc, out_instr, exp_e[36:32], exp_e[31:0]);
        end
      end
    end
    check_drained("halt_resume");
`else
    total++;
    if (halted !== 1'b0) begin
      bad++;
      $display("FAIL halt_disabled got h=%b want 0", halted);
    end
`endif
    mem[6] = 32'h1000_0006;
  endtask

  task automatic test_mid_reset();
    logic seen;
    seen = 1'b0;
    do_reset();
    out_ready = 1'b1;
    do_start();
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk); #1;
      if (out_valid && out_pc == 5'd5) seen = 1'b1;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL midrst_reach got no pc=5 want pc=5 valid");
    end
    #1 rst_n = 1'b0;
    #1;
    total++;
    if ({out_valid, out_instr, out_pc, imem_addr, halted} !== {1'b0, 32'd0, 5'd0, 5'd0, 1'b0}) begin
      bad++;
      $display("FAIL midrst_vals got v=%b i=%h p=%0d a=%0d h=%b want 0/0/0/0/0",
               out_valid, out_instr, out_pc, imem_addr, halted);
    end
    @(negedge clk); rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1;
      total++;
      if ({out_valid, imem_addr} !== {1'b0, 5'd0}) begin
        bad++;
        $display("FAIL midrst_idle got v=%b a=%0d want v=0 a=0", out_valid, imem_addr);
      end
    end
    push_range(0, 3);
    do_start();
    for (int c = 0; c < 20 && sb.size() > 0; c++) begin
      @(negedge clk); #2;
      if (out_valid && out_ready && !redirect_valid) begin
        exp_e = sb.pop_front(); total++;
        if ({out_pc, out_instr} !== exp_e) begin
          bad++;
          $display("FAIL midrst_restart got pc=%0d instr=%h want pc=%0d instr=%h", out_pc, out_instr, exp_e[36:32], exp_e[31:0]);
        end
      end
    end
    check_drained("midrst_restart");
  endtask

  initial begin
    total = 0;
    bad = 0;
    for (int k = 0; k < 32; k++) mem[k] = 32'h1000_0000 + 32'(k);
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect(1'b0);
    test_redirect(1'b1);
    test_halt();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
